// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register indices, exception codes, handler address, PrID value.
package cp0_ctrl_pkg;

    localparam logic [4:0]  CP0_IDX_SR    = 5'd12;
    localparam logic [4:0]  CP0_IDX_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_IDX_EPC   = 5'd14;
    localparam logic [4:0]  CP0_IDX_PRID  = 5'd15;

    localparam logic [4:0]  EXC_INT  = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [4:0]  EXC_RI   = 5'd10;
    localparam logic [4:0]  EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE   = 32'h4255_4141;

    // Implemented SR bits: IM[15:10], EXL[1], IE[0]
    localparam logic [31:0] SR_WMASK   = 32'h0000_FC03;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 for a 5-stage MIPS pipeline: SR/Cause/EPC, interrupt and exception request.
// Optional macro CP0_PRID_EN makes index 15 read the PrID constant.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [31:0] r_sr;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_sr_nxt;
    logic [31:0] w_cause_nxt;
    logic [31:0] w_epc_nxt;

    assign w_int_req = (|(HWInt & r_sr[15:10])) & r_sr[0] & ~r_sr[1];
    assign w_exc_req = (ExcCodeIn != EXC_INT) & ~r_sr[1];
    assign w_req     = w_int_req | w_exc_req;
    assign Req       = w_req;
    assign EPCOut    = r_epc;

    // Next-state: exception entry beats mtc0; eret clear applies after any mtc0 to SR
    always_comb begin
        w_sr_nxt           = r_sr;
        w_cause_nxt        = r_cause;
        w_epc_nxt          = r_epc;
        w_cause_nxt[15:10] = HWInt;
        if (w_req) begin
            w_sr_nxt[1]       = 1'b1;
            w_cause_nxt[31]   = BDIn;
            w_cause_nxt[6:2]  = w_int_req ? EXC_INT : ExcCodeIn;
            w_epc_nxt         = word_align(BDIn ? (VPC - 32'd4) : VPC);
        end else begin
            if (en) begin
                case (CP0Add)
                    CP0_IDX_SR:  w_sr_nxt  = CP0In & SR_WMASK;
                    CP0_IDX_EPC: w_epc_nxt = word_align(CP0In);
                    default:     w_sr_nxt  = r_sr;
                endcase
            end else begin
                w_sr_nxt = r_sr;
            end
            if (EXLClr) begin
                w_sr_nxt[1] = 1'b0;
            end else begin
                w_sr_nxt[1] = w_sr_nxt[1];
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr    <= 32'h0000_0000;
            r_cause <= 32'h0000_0000;
            r_epc   <= 32'h0000_0000;
        end else begin
            r_sr    <= w_sr_nxt;
            r_cause <= w_cause_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    // mfc0 read mux on current register values
    always_comb begin
        CP0Out = 32'h0000_0000;
        case (CP0Add)
            CP0_IDX_SR:    CP0Out = r_sr;
            CP0_IDX_CAUSE: CP0Out = r_cause;
            CP0_IDX_EPC:   CP0Out = r_epc;
`ifdef CP0_PRID_EN
            CP0_IDX_PRID:  CP0Out = PRID_VALUE;
`endif
            default:       CP0Out = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl (honours CP0_PRID_EN if defined).
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_checks = 0;
    int n_errors = 0;

    cp0_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        CP0Add = idx;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prid_exp;
        reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'h0;
        VPC = 32'h0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

        // Reset state
        #2;
        chk("rst_req", {31'd0, Req}, 32'd0);
        chk("rst_epcout", EPCOut, 32'h0);
        chk_rd("rst_sr", 5'd12, 32'h0);
        chk_rd("rst_cause", 5'd13, 32'h0);
        chk_rd("rst_epc", 5'd14, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        edge_step();

        // Plain exception (Ov)
        ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 1'b0;
        #1 chk("exc_req", {31'd0, Req}, 32'd1);
        edge_step();
        ExcCodeIn = 5'd0;
        #1 chk("exc_req_after", {31'd0, Req}, 32'd0);
        chk("exc_epc", EPCOut, 32'h0000_3010);
        chk_rd("exc_cause", 5'd13, 32'h0000_0030);
        chk_rd("exc_sr", 5'd12, 32'h0000_0002);
        ExcCodeIn = 5'd5;
        #1 chk("exl_blocks_exc", {31'd0, Req}, 32'd0);
        ExcCodeIn = 5'd0;

        // eret
        EXLClr = 1'b1;
        edge_step();
        EXLClr = 1'b0;
        chk_rd("eret_sr", 5'd12, 32'h0);
        chk("eret_epc", EPCOut, 32'h0000_3010);

        // Delay-slot exception
        ExcCodeIn = 5'd4; VPC = 32'h0000_3024; BDIn = 1'b1;
        #1 chk("ds_req", {31'd0, Req}, 32'd1);
        edge_step();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        chk("ds_epc", EPCOut, 32'h0000_3020);
        chk_rd("ds_cause", 5'd13, 32'h8000_0010);
        EXLClr = 1'b1;
        edge_step();
        EXLClr = 1'b0;

        // mtc0 EPC (aligned), no same-cycle bypass; Cause read-only
        en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_1237;
        #1 chk("nobypass_epc", CP0Out, 32'h0000_3020);
        edge_step();
        chk("mtc0_epc", EPCOut, 32'h0000_1234);
        CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
        edge_step();
        chk_rd("cause_ro", 5'd13, 32'h8000_0010);
        CP0Add = 5'd12; CP0In = 32'hFFFF_0401;
        edge_step();
        en = 1'b0;
        chk_rd("mtc0_sr_mask", 5'd12, 32'h0000_0401);

        // Interrupt, also simultaneous with an RI exception
        HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h0000_3040;
        #1 chk("int_req", {31'd0, Req}, 32'd1);
        edge_step();
        ExcCodeIn = 5'd0;
        chk_rd("int_cause", 5'd13, 32'h0000_0400);
        chk("int_epc", EPCOut, 32'h0000_3040);
        chk_rd("int_sr", 5'd12, 32'h0000_0403);
        HWInt = 6'd0; EXLClr = 1'b1;
        edge_step();
        EXLClr = 1'b0;
        chk_rd("int_eret_sr", 5'd12, 32'h0000_0401);

        // IM masked: no interrupt, IP still sampled
        en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0001;
        edge_step();
        en = 1'b0;
        HWInt = 6'b000001;
        #1 chk("im_masked_req", {31'd0, Req}, 32'd0);
        edge_step();
        chk_rd("ip_sampled", 5'd13, 32'h0000_0400);
        HWInt = 6'd0;
        edge_step();

        // mtc0 collides with exception: exception wins
        en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_5000;
        ExcCodeIn = 5'd10; VPC = 32'h0000_3100; BDIn = 1'b0;
        #1 chk("coll_req", {31'd0, Req}, 32'd1);
        edge_step();
        en = 1'b0; ExcCodeIn = 5'd0;
        chk("coll_epc", EPCOut, 32'h0000_3100);
        chk_rd("coll_cause", 5'd13, 32'h0000_0028);
        chk_rd("coll_sr", 5'd12, 32'h0000_0003);
        EXLClr = 1'b1;
        edge_step();
        chk_rd("eret2_sr", 5'd12, 32'h0000_0001);
        edge_step();
        EXLClr = 1'b0;
        chk_rd("exlclr_noop", 5'd12, 32'h0000_0001);
        chk("eret2_epc", EPCOut, 32'h0000_3100);

        // Unimplemented / PrID
`ifdef CP0_PRID_EN
        prid_exp = 32'h4255_4141;
`else
        prid_exp = 32'h0000_0000;
`endif
        chk_rd("unimpl_0", 5'd0, 32'h0);
        chk_rd("prid", 5'd15, prid_exp);

        // Asynchronous mid-cycle reset, then reset beats a request
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("arst_epcout", EPCOut, 32'h0);
        chk("arst_req", {31'd0, Req}, 32'd0);
        chk_rd("arst_sr", 5'd12, 32'h0);
        chk_rd("arst_cause", 5'd13, 32'h0);
        chk_rd("arst_epc", 5'd14, 32'h0);
        ExcCodeIn = 5'd12; VPC = 32'h0000_3010;
        edge_step();
        ExcCodeIn = 5'd0;
        chk("rst_wins_epc", EPCOut, 32'h0);
        chk_rd("rst_wins_sr", 5'd12, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        edge_step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL provide clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide en  input  1  mtc0 write strobe from M stage.
REQ-004 SHALL provide CP0Add  input  5  register index for mtc0/mfc0.
REQ-005 SHALL provide CP0In  input  32  mtc0 write data.
REQ-006 SHALL provide CP0Out  output  32  mfc0 read data, combinational on CP0Add.
REQ-007 SHALL provide VPC  input  32  PC of the instruction in M stage.
REQ-008 SHALL provide BDIn  input  1  M-stage instruction sits in a delay slot.
REQ-009 SHALL provide ExcCodeIn  input  5  M-stage exception code, 0 = none.
REQ-010 SHALL provide HWInt  input  6  external interrupt lines.
REQ-011 SHALL provide EXLClr  input  1  eret in M stage, clears SR.EXL.
REQ-012 SHALL provide EPCOut  output  32  current EPC register value, used as the eret target.
REQ-013 SHALL provide Req  output  1  combinational flush/redirect to the handler; drives the pipeline-register Req inputs.

Function
REQ-014 SHALL hold SR (idx 12) with fields IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-015 SHALL hold Cause (idx 13) with fields BD[31], IP[15:10] and ExcCode[6:2]; all other bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-016 SHALL hold EPC (idx 14) as 32 bits, always word-aligned (bits[1:0] forced 0).
REQ-017 IntReq SHALL equal |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
REQ-018 ExcReq SHALL equal (ExcCodeIn != 0) & ~SR.EXL.
REQ-019 Req SHALL equal IntReq | ExcReq, with zero cycles of latency (combinational).
REQ-020 On a clock edge with Req=1, SR.EXL SHALL become 1.
REQ-021 On a clock edge with Req=1, Cause.BD SHALL be loaded with BDIn.
REQ-022 On a clock edge with Req=1, Cause.ExcCode SHALL be loaded with 0 if IntReq, else with ExcCodeIn; an interrupt takes priority over a simultaneous exception.
REQ-023 On a clock edge with Req=1, EPC SHALL be loaded with BDIn ? VPC-4 : VPC.
REQ-024 Cause.IP SHALL be sampled from HWInt every cycle, regardless of Req.
REQ-025 An mtc0 (en=1, Req=0) to index 12 SHALL write only the IM, EXL and IE bits; to index 14 SHALL write EPC with bits[1:0] cleared; writes to any other index SHALL be ignored.
REQ-026 When Req=1 and en=1 in the same cycle, the mtc0 write SHALL be dropped and the exception update SHALL win.
REQ-027 EXLClr=1 SHALL clear SR.EXL at the next edge; EXLClr with EXL already 0 SHALL have no effect.
REQ-028 Reads of an unimplemented index SHALL return 0.
REQ-029 mfc0 SHALL return the pre-edge register value; there is no write-to-read bypass in the same cycle.

Reset
REQ-030 While reset=1, SR, Cause and EPC SHALL be 0 immediately, independent of clk.
REQ-031 Consequently, during and directly after reset, Req SHALL be 0 and EPCOut SHALL be 0.
REQ-032 Reset asserted in the same cycle as Req SHALL win; no state is captured.

Configuration
REQ-033 With macro CP0_PRID_EN defined, index 15 (PrID) SHALL read the constant 32'h4255_4141.
REQ-034 Without CP0_PRID_EN, index 15 SHALL read 0 like any unimplemented index.

Structure
REQ-035 The shared package SHALL hold the register indices (12/13/14/15), the ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), the handler address 32'h0000_4180 and the PrID constant.
REQ-036 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-037 Reset: assert reset mid-cycle -> all registers 0 asynchronously, Req=0, CP0Out=0 for indices 12/13/14.
REQ-038 Exception: ExcCodeIn=12, VPC=0x3010, BDIn=0 -> Req=1 the same cycle; after the edge EPC=0x3010, ExcCode=12, EXL=1, and Req=0 on the next cycle.
REQ-039 Delay slot: ExcCodeIn=4, VPC=0x3024, BDIn=1 -> EPC=0x3020, Cause.BD=1.
REQ-040 Interrupt: mtc0 SR=0x0000_0401, then HWInt=6'b000001 -> Req=1, ExcCode=0, Cause.IP=6'b000001; with SR.IM=0 the same HWInt -> Req=0.
REQ-041 Collision: en=1, CP0Add=14, CP0In=0x5000 together with ExcCodeIn=10, VPC=0x3100 -> EPC=0x3100.
REQ-042 eret: EXL=1, EXLClr=1 -> EXL=0 after one edge and EPCOut unchanged; with CP0_PRID_EN, reading index 15 -> 0x4255_4141.
